// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// One transaction outstanding at a time; a cancelled fetch completes downstream but its response is dropped.
module sram_like_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester holds req and its fields stable until it sees addr_ok
  // in the same cycle; data_ok is a single-cycle pulse with rdata valid alongside it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner_data;
  logic        cancel_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic grant_data, grant_inst, grant_any, resp_done;

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state == S_IDLE) begin
      grant_data = data_req && (DATA_PRIO || !inst_req);
      grant_inst = inst_req && !grant_data;
    end
    grant_any = grant_data || grant_inst;
    resp_done = (state == S_WAIT) && mem_data_ok;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any)   state_nxt = S_REQ;
      S_REQ:   if (mem_addr_ok) state_nxt = S_WAIT;
      S_WAIT:  if (mem_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      owner_data <= 1'b0;
      cancel_q   <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wstrb_q    <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner_data <= grant_data;
        cancel_q   <= grant_inst && inst_cancel;
        if (grant_data) begin
          wr_q    <= data_wr;
          size_q  <= data_size;
          wstrb_q <= data_wstrb;
          addr_q  <= data_addr;
          wdata_q <= data_wdata;
        end else begin
          wr_q    <= 1'b0;
          size_q  <= 2'd2;
          wstrb_q <= 4'd0;
          addr_q  <= inst_addr;
          wdata_q <= 32'd0;
        end
      end else if (resp_done) begin
        cancel_q <= 1'b0;
      end else if (state != S_IDLE && !owner_data && inst_cancel) begin
        cancel_q <= 1'b1;
      end
    end
  end

  // Every upstream-visible strobe is forced low while reset is held.
  always_comb begin
    inst_addr_ok = grant_inst && !reset;
    data_addr_ok = grant_data && !reset;
    inst_data_ok = resp_done && !owner_data && !cancel_q && !reset;
    data_data_ok = resp_done && owner_data && !reset;
    inst_rdata   = reset ? 32'd0 : mem_rdata;
    data_rdata   = reset ? 32'd0 : mem_rdata;
    mem_req      = (state == S_REQ) && !reset;
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_wstrb    = wstrb_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    state_dbg    = state;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change 1ns after posedge, outputs are checked at negedge.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size, state_dbg;
  logic [3:0]  mem_wstrb;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic check_strobes(input string tag, input logic ia, input logic id,
                               input logic da, input logic dd, input logic mr);
    chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(ia));
    chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(id));
    chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(da));
    chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(dd));
    chk({tag, ".mem_req"},      32'(mem_req),      32'(mr));
  endtask

  initial begin
    quiet_inputs();
    reset = 1;

    // Reset: requests and stray responses present, everything must stay quiet.
    next_cycle();
    inst_req = 1; data_req = 1; mem_data_ok = 1; mem_rdata = 32'h12345678;
    to_check();
    check_strobes("reset", 0, 0, 0, 0, 0);
    chk("reset.inst_rdata", inst_rdata, 32'h0);
    chk("reset.data_rdata", data_rdata, 32'h0);
    next_cycle();
    chk("reset.state", 32'(state_dbg), 32'd0);
    reset = 0;
    quiet_inputs();
    to_check();
    check_strobes("idle", 0, 0, 0, 0, 0);

    // Single fetch.
    next_cycle();
    inst_req = 1; inst_addr = 32'h1c000000;
    to_check();
    check_strobes("fetch.grant", 1, 0, 0, 0, 0);
    next_cycle();
    inst_req = 0;
    to_check();
    check_strobes("fetch.req", 0, 0, 0, 0, 1);
    chk("fetch.mem_addr", mem_addr, 32'h1c000000);
    chk("fetch.mem_wr", 32'(mem_wr), 32'd0);
    chk("fetch.mem_size", 32'(mem_size), 32'd2);
    chk("fetch.mem_wstrb", 32'(mem_wstrb), 32'd0);
    next_cycle();
    mem_addr_ok = 1;
    to_check();
    chk("fetch.req_hold", 32'(mem_req), 32'd1);
    next_cycle();
    mem_addr_ok = 0;
    to_check();
    check_strobes("fetch.wait", 0, 0, 0, 0, 0);
    chk("fetch.state_wait", 32'(state_dbg), 32'd2);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h02800c06;
    to_check();
    check_strobes("fetch.resp", 0, 1, 0, 0, 0);
    chk("fetch.inst_rdata", inst_rdata, 32'h02800c06);
    next_cycle();
    quiet_inputs();
    to_check();
    check_strobes("fetch.done", 0, 0, 0, 0, 0);
    chk("fetch.state_idle", 32'(state_dbg), 32'd0);

    // Contention: data store wins, inst waits until the IDLE cycle after data_ok.
    next_cycle();
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hf;
    data_addr = 32'h1c008000; data_wdata = 32'hdeadbeef;
    to_check();
    check_strobes("cont.grant", 0, 0, 1, 0, 0);
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    to_check();
    check_strobes("cont.req", 0, 0, 0, 0, 1);
    chk("cont.mem_wr", 32'(mem_wr), 32'd1);
    chk("cont.mem_wdata", mem_wdata, 32'hdeadbeef);
    chk("cont.mem_addr", mem_addr, 32'h1c008000);
    chk("cont.mem_wstrb", 32'(mem_wstrb), 32'hf);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0;
    to_check();
    check_strobes("cont.resp", 0, 0, 0, 1, 0);
    next_cycle();
    mem_data_ok = 0;
    to_check();
    check_strobes("cont.inst_grant", 1, 0, 0, 0, 0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 1;
    to_check();
    chk("cont.inst_addr", mem_addr, 32'h1c000004);
    chk("cont.inst_wr", 32'(mem_wr), 32'd0);
    chk("cont.inst_wdata", mem_wdata, 32'd0);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hcafef00d;
    to_check();
    check_strobes("cont.inst_resp", 0, 1, 0, 0, 0);
    chk("cont.inst_rdata", inst_rdata, 32'hcafef00d);
    next_cycle();
    quiet_inputs();

    // Cancel in WAIT: response dropped, next fetch proceeds normally.
    inst_req = 1; inst_addr = 32'h1c000010;
    to_check();
    check_strobes("cwait.grant", 1, 0, 0, 0, 0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; inst_cancel = 1;
    to_check();
    chk("cwait.state", 32'(state_dbg), 32'd2);
    next_cycle();
    inst_cancel = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    inst_req = 1; inst_addr = 32'h1c000020;
    to_check();
    check_strobes("cwait.dropped", 0, 0, 0, 0, 0);
    next_cycle();
    mem_data_ok = 0;
    to_check();
    check_strobes("cwait.regrant", 1, 0, 0, 0, 0);
    next_cycle();
    inst_req = 0; mem_addr_ok = 1;
    to_check();
    chk("cwait.addr2", mem_addr, 32'h1c000020);
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h22222222;
    to_check();
    check_strobes("cwait.resp2", 0, 1, 0, 0, 0);
    chk("cwait.rdata2", inst_rdata, 32'h22222222);
    next_cycle();
    quiet_inputs();

    // Cancel asserted together with the inst grant.
    inst_req = 1; inst_addr = 32'h1c000030; inst_cancel = 1;
    to_check();
    check_strobes("cgrant.grant", 1, 0, 0, 0, 0);
    next_cycle();
    inst_req = 0; inst_cancel = 0; mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h33333333;
    to_check();
    check_strobes("cgrant.dropped", 0, 0, 0, 0, 0);
    next_cycle();
    quiet_inputs();

    // Backpressure: latched fields hold while upstream inputs wander.
    data_req = 1; data_wr = 1; data_size = 1; data_wstrb = 4'b1100;
    data_addr = 32'h1c000102; data_wdata = 32'hbeef0000;
    to_check();
    check_strobes("bp.grant", 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      inst_req = 1; inst_addr = 32'h1c000040 + 32'(i);
      data_req = 1; data_wr = 0; data_size = 0; data_wstrb = 4'(i);
      data_addr = 32'h0000ff00 + 32'(i); data_wdata = 32'(i);
      to_check();
      check_strobes("bp.hold", 0, 0, 0, 0, 1);
      chk("bp.mem_addr", mem_addr, 32'h1c000102);
      chk("bp.mem_size", 32'(mem_size), 32'd1);
      chk("bp.mem_wstrb", 32'(mem_wstrb), 32'hc);
      chk("bp.mem_wdata", mem_wdata, 32'hbeef0000);
      chk("bp.mem_wr", 32'(mem_wr), 32'd1);
    end
    next_cycle();
    quiet_inputs();
    mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1;
    to_check();
    check_strobes("bp.resp", 0, 0, 0, 1, 0);
    next_cycle();
    quiet_inputs();

    // Reset in WAIT of a data load: no data_ok, even for a stale response.
    data_req = 1; data_addr = 32'h1c000200; data_size = 2;
    to_check();
    check_strobes("rst.grant", 0, 0, 1, 0, 0);
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; reset = 1;
    to_check();
    check_strobes("rst.held", 0, 0, 0, 0, 0);
    next_cycle();
    reset = 0; mem_data_ok = 1; mem_rdata = 32'h44444444;
    to_check();
    check_strobes("rst.stale", 0, 0, 0, 0, 0);
    chk("rst.state", 32'(state_dbg), 32'd0);
    next_cycle();
    quiet_inputs();

    // Byte load with a cancel pulse that must not affect a data transaction.
    data_req = 1; data_wr = 0; data_size = 0; data_wstrb = 4'b1000;
    data_addr = 32'h1c000003;
    to_check();
    check_strobes("byte.grant", 0, 0, 1, 0, 0);
    next_cycle();
    data_req = 0; inst_cancel = 1;
    to_check();
    chk("byte.mem_size", 32'(mem_size), 32'd0);
    chk("byte.mem_addr", mem_addr, 32'h1c000003);
    chk("byte.mem_wstrb", 32'(mem_wstrb), 32'h8);
    chk("byte.mem_wr", 32'(mem_wr), 32'd0);
    next_cycle();
    inst_cancel = 0; mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'ha5a5a5a5;
    to_check();
    check_strobes("byte.resp", 0, 0, 0, 1, 0);
    chk("byte.data_rdata", data_rdata, 32'ha5a5a5a5);
    next_cycle();
    quiet_inputs();
    to_check();
    check_strobes("byte.done", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
